fdiv_ctrl: RTL and testbench
============================

Name: fdiv_ctrl

Overview:
Run-time programmable integer clock divider with a configuration controller. It produces div_clk at clk/N with 50% duty for both even and odd N; odd N uses a negedge half-cycle stage. A valid/ready config port accepts new ratio and enable requests. Changes are applied only at a div_clk period boundary, so div_clk never glitches or truncates a period. Sits beside the fixed dividers and replaces hard-wired ratios wherever software or a sequencer must retune a derived clock.

Parameters:
CNT_W, 8, width of ratio and counter; ratios up to 2^CNT_W-1
DIV_MIN, 2, smallest legal ratio; smaller requests are rejected
DIV_DEFAULT, 5, ratio loaded at reset; must be >= DIV_MIN

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cfg_valid  in  1  config request valid
cfg_ready  out  1  controller can accept a request
cfg_div  in  CNT_W  requested ratio N
cfg_en  in  1  requested output state: 1 = run, 0 = stop
div_clk  out  1  divided clock
div_active  out  1  high when state != OFF
period_strobe  out  1  one clk-cycle pulse at the start of each div_clk period
cfg_err  out  1  one-cycle pulse: request rejected because cfg_div < DIV_MIN

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous and active-low.
- Reset values: state=OFF, cur_div=DIV_DEFAULT, cnt=0, p=0, n=0, div_clk=0, div_active=0, period_strobe=0, cfg_err=0, cfg_ready=1.
- Reset asserted mid-operation clears all of the above immediately, including the negedge flop.
- Core, with H = cur_div>>1:
  - cnt counts 0..cur_div-1 on posedge and wraps to 0.
  - p is registered and set to (cnt_next < H).
  - n samples p on negedge.
  - div_clk = p when cur_div is even; div_clk = p|n when cur_div is odd.
  - Result: high time is N/2 clk periods (x.5 for odd N), period is exactly N clk periods.
- period_strobe = (state != OFF) && cnt==0.
- Handshake:
  - A transfer occurs when cfg_valid & cfg_ready at a posedge.
  - cfg_ready=1 in OFF and RUN, 0 in PEND.
  - Inputs need only be stable in the transfer cycle.
- Invalid request (cfg_div < DIV_MIN):
  - cfg_err pulses on the next cycle.
  - No state or ratio change; ready stays 1.
- State OFF:
  - Accept with en=1: cur_div <= cfg_div, cnt <= 0, p <= 1, go RUN. div_clk rises at that same edge.
  - Accept with en=0: cur_div <= cfg_div, stay OFF.
- State RUN: accept stores pend_div/pend_en and goes to PEND. Counting continues at the old ratio.
- State PEND, at the edge where cnt == cur_div-1:
  - pend_en=1: cur_div <= pend_div, cnt <= 0, p <= 1, go RUN.
  - pend_en=0: cur_div <= pend_div, cnt <= 0, p <= 0, go OFF. div_clk stays 0.
- Boundary safety: in the last cycle of any period p=0 and n=0, so odd/even switches at a boundary are glitch-free.
- A same-ratio request still takes the PEND path; the resulting div_clk is unchanged.
- Width rules:
  - All compares are unsigned CNT_W.
  - cur_div-1 never underflows because cur_div >= DIV_MIN >= 2.
  - N=2 gives 1/1 high/low; N=3 gives 1.5/1.5.

Decomposition:
- Package fdiv_pkg: state encoding (OFF, RUN, PEND) and the default CNT_W constant.
- Sub-module fdiv_core: counter, p/n flops and output mux. Inputs: clk, rst_n, run, load, load_div. Outputs: div_clk, cnt_last, cnt_zero.
- fdiv_ctrl holds the FSM, pending registers and handshake.

Test Plan:
- clk 10 ns. Reset released, request {5,1}: div_clk high 25 ns / low 25 ns, period 50 ns; period_strobe every 5 clks; div_active=1.
- Running N=5, request {4,1} at cnt=2: cfg_ready=0 until the boundary. The current period completes at 50 ns, then 20/20 ns. Exactly one strobe per period, no runt pulse.
- Request {1,1} while running N=4: cfg_err pulses one cycle, cfg_ready stays 1, ratio remains 4.
- Running N=3, request {6,0}: the current 30 ns period completes (15 ns high), then div_clk=0 and div_active=0. A following {6,1} gives 30/30 ns.
- rst_n low 3 ns into the div_clk high phase (N=7): div_clk=0 immediately, state OFF, cfg_ready=1, cur_div=5.
- Extremes: N=2 gives 10/10 ns; N=255 gives high 1275 ns / period 2550 ns. Back-to-back requests are stalled by cfg_ready=0 and not lost.

Source files
------------

// File: rtl/fdiv_pkg.sv
// Shared types and defaults for the programmable clock divider.
package fdiv_pkg;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;
endpackage

// File: rtl/fdiv_if.sv
// Config request channel: ratio and enable under valid/ready.
interface fdiv_if #(parameter int CNT_W = 8);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_en;

  modport master (output cfg_valid, cfg_div, cfg_en, input cfg_ready);
  modport slave  (input cfg_valid, cfg_div, cfg_en, output cfg_ready);
endinterface

// File: rtl/fdiv_core.sv
// Ratio counter plus posedge/negedge phase flops giving a 50% duty clk/N.
module fdiv_core
  import fdiv_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DIV_DEFAULT = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             load,
  input  logic [CNT_W-1:0] load_div,
  output logic             div_clk,
  output logic             cnt_last,
  output logic             cnt_zero
);
  logic [CNT_W-1:0] cur_div, cnt, cnt_next, half;
  logic             p, n;

  assign half     = cur_div >> 1;
  assign cnt_last = (cnt == cur_div - CNT_W'(1));
  assign cnt_zero = (cnt == '0);
  assign cnt_next = cnt_last ? '0 : cnt + CNT_W'(1);

  // A load always starts a fresh period; p follows run so a stop holds the clock low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_div <= CNT_W'(DIV_DEFAULT);
      cnt     <= '0;
      p       <= 1'b0;
    end else if (load) begin
      cur_div <= load_div;
      cnt     <= '0;
      p       <= run;
    end else if (run) begin
      cnt <= cnt_next;
      p   <= (cnt_next < half);
    end else begin
      cnt <= '0;
      p   <= 1'b0;
    end
  end

  // Half-cycle stretch of p for odd ratios.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) n <= 1'b0;
    else        n <= p;
  end

  assign div_clk = cur_div[0] ? (p | n) : p;
endmodule

// File: rtl/fdiv_ctrl.sv
// Config FSM: accepts ratio/enable requests and applies them on period boundaries.
module fdiv_ctrl
  import fdiv_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DIV_MIN     = 2,
  parameter int DIV_DEFAULT = 5
) (
  input  logic   clk,
  input  logic   rst_n,
  fdiv_if.slave  cfg,
  output logic   div_clk,
  output logic   div_active,
  output logic   period_strobe,
  output logic   cfg_err
);
  localparam logic [CNT_W-1:0] MIN_V = CNT_W'(DIV_MIN);

  state_t           state, state_n;
  logic [CNT_W-1:0] pend_div, load_div;
  logic             pend_en, run, load, cnt_last, cnt_zero, accept, bad;

  assign accept        = cfg.cfg_valid && cfg.cfg_ready;
  assign bad           = (cfg.cfg_div < MIN_V);
  assign cfg.cfg_ready = (state != ST_PEND);
  assign div_active    = (state != ST_OFF);
  assign period_strobe = div_active && cnt_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_OFF;
      pend_div <= CNT_W'(DIV_DEFAULT);
      pend_en  <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      state   <= state_n;
      cfg_err <= accept && bad;
      if (state == ST_RUN && accept && !bad) begin
        pend_div <= cfg.cfg_div;
        pend_en  <= cfg.cfg_en;
      end
    end
  end

  always_comb begin
    state_n  = state;
    load     = 1'b0;
    load_div = cfg.cfg_div;
    run      = (state != ST_OFF);
    unique case (state)
      ST_OFF: if (accept && !bad) begin
        load    = 1'b1;
        run     = cfg.cfg_en;
        state_n = cfg.cfg_en ? ST_RUN : ST_OFF;
      end
      ST_RUN: if (accept && !bad) state_n = ST_PEND;
      ST_PEND: if (cnt_last) begin
        load     = 1'b1;
        load_div = pend_div;
        run      = pend_en;
        state_n  = pend_en ? ST_RUN : ST_OFF;
      end
      default: state_n = ST_OFF;
    endcase
  end

  fdiv_core #(.CNT_W(CNT_W), .DIV_DEFAULT(DIV_DEFAULT)) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .load     (load),
    .load_div (load_div),
    .div_clk  (div_clk),
    .cnt_last (cnt_last),
    .cnt_zero (cnt_zero)
  );
endmodule

// File: tb/tb_fdiv_ctrl.sv
// Directed bench for fdiv_ctrl: ratio table plus handshake/stop/reset sequences.
module tb_fdiv_ctrl;
  logic clk, rst_n, div_clk, div_active, period_strobe, cfg_err;
  int   total = 0, bad = 0, strobes = 0;

  fdiv_if #(.CNT_W(8)) cfg_if ();

  fdiv_ctrl #(.CNT_W(8), .DIV_MIN(2), .DIV_DEFAULT(5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg           (cfg_if),
    .div_clk       (div_clk),
    .div_active    (div_active),
    .period_strobe (period_strobe),
    .cfg_err       (cfg_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) if (period_strobe) strobes++;

  typedef struct {
    logic [7:0] div;
    longint     hi;
    longint     per;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Polls 1 ns after each clk edge so measured intervals are exact.
  task automatic wait_lvl(input logic v, output longint t, output bit ok);
    int k = 0;
    while (div_clk !== v && k < 700) begin
      #5;
      k++;
    end
    ok = (div_clk === v);
    t  = $time;
  endtask

  task automatic send(input logic [7:0] d, input logic e, output int stall);
    stall = 0;
    @(negedge clk);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_div   = d;
    cfg_if.cfg_en    = e;
    while (!cfg_if.cfg_ready && stall < 3000) begin
      @(negedge clk);
      stall++;
    end
    @(posedge clk);
    #1;
    cfg_if.cfg_valid = 1'b0;
    if (stall >= 3000) chk("send_timeout", stall, 0);
  endtask

  task automatic measure(input string name, input longint hi, input longint per);
    longint t0, t1, t2;
    bit     ok0, ok1, ok2, ok3;
    int     s0;
    wait_lvl(1'b0, t0, ok0);
    wait_lvl(1'b1, t0, ok1);
    s0 = strobes;
    wait_lvl(1'b0, t1, ok2);
    wait_lvl(1'b1, t2, ok3);
    if (!(ok0 && ok1 && ok2 && ok3)) chk({name, "_timeout"}, 0, 1);
    else begin
      chk({name, "_hi"}, t1 - t0, hi);
      chk({name, "_per"}, t2 - t0, per);
      chk({name, "_strobes"}, strobes - s0, 1);
    end
  endtask

  initial begin
    longint t0, t1, t2;
    bit     ok;
    int     stall;

    vecs[0] = '{8'd5,   25,   50};
    vecs[1] = '{8'd2,   10,   20};
    vecs[2] = '{8'd3,   15,   30};
    vecs[3] = '{8'd4,   20,   40};
    vecs[4] = '{8'd7,   35,   70};
    vecs[5] = '{8'd6,   30,   60};
    vecs[6] = '{8'd255, 1275, 2550};

    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_div   = 8'd0;
    cfg_if.cfg_en    = 1'b0;
    rst_n = 1'b0;
    #23 rst_n = 1'b1;
    #1;
    chk("rst_div_clk", div_clk, 0);
    chk("rst_active", div_active, 0);
    chk("rst_ready", cfg_if.cfg_ready, 1);
    chk("rst_strobe", period_strobe, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_cur_div", dut.u_core.cur_div, 5);

    // Start from OFF: div_clk rises on the accept edge.
    send(8'd5, 1'b1, stall);
    chk("start_div_clk", div_clk, 1);
    chk("start_active", div_active, 1);
    chk("start_strobe", period_strobe, 1);

    for (int i = 0; i < 7; i++) begin
      send(vecs[i].div, 1'b1, stall);
      measure($sformatf("vec%0d_n%0d", i, vecs[i].div), vecs[i].hi, vecs[i].per);
    end

    // Retune N=5 -> 4 mid-period: old period completes, ready low meanwhile.
    send(8'd5, 1'b1, stall);
    measure("re5", 25, 50);
    wait_lvl(1'b0, t0, ok);
    wait_lvl(1'b1, t0, ok);
    @(posedge clk);
    @(posedge clk);
    #1;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_div   = 8'd4;
    cfg_if.cfg_en    = 1'b1;
    @(posedge clk);
    #1;
    cfg_if.cfg_valid = 1'b0;
    chk("pend_ready", cfg_if.cfg_ready, 0);
    wait_lvl(1'b1, t2, ok);
    chk("pend_boundary", t2 - t0, 50);
    chk("pend_ready_back", cfg_if.cfg_ready, 1);
    measure("after_pend_n4", 20, 40);

    // Rejected ratio while running N=4.
    send(8'd1, 1'b1, stall);
    chk("err_pulse", cfg_err, 1);
    chk("err_ready", cfg_if.cfg_ready, 1);
    @(posedge clk);
    #1;
    chk("err_once", cfg_err, 0);
    chk("err_keep_div", dut.u_core.cur_div, 4);
    measure("err_n4", 20, 40);

    // Stop request while running N=3.
    send(8'd3, 1'b1, stall);
    measure("stop_n3", 15, 30);
    wait_lvl(1'b1, t0, ok);
    send(8'd6, 1'b0, stall);
    wait_lvl(1'b0, t1, ok);
    chk("stop_last_hi", t1 - t0, 15);
    repeat (4) @(posedge clk);
    #1;
    chk("stop_active", div_active, 0);
    chk("stop_div_clk", div_clk, 0);
    chk("stop_ready", cfg_if.cfg_ready, 1);
    wait_lvl(1'b1, t2, ok);
    chk("stop_stays_low", ok, 0);
    send(8'd6, 1'b1, stall);
    measure("restart_n6", 30, 60);

    // Back-to-back: the second request stalls until the first is applied.
    send(8'd4, 1'b1, stall);
    send(8'd7, 1'b1, stall);
    chk("b2b_stalled", stall > 0, 1);
    measure("b2b_n7", 35, 70);

    // Async reset 3 ns into the high phase.
    wait_lvl(1'b0, t0, ok);
    wait_lvl(1'b1, t0, ok);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_div_clk", div_clk, 0);
    chk("arst_active", div_active, 0);
    chk("arst_ready", cfg_if.cfg_ready, 1);
    chk("arst_cur_div", dut.u_core.cur_div, 5);
    chk("arst_n", dut.u_core.n, 0);
    #10 rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
